afifo_rd_port: RTL and testbench

//  Read-domain endpoint of the dual-clock FIFO. Receives the write side's Gray pointer and

---
 rtl/afifo_rd_port.sv | 137 +++++++++++++
 tb/tb_afifo_rd_port.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_port.sv
// Read-side endpoint of the dual-clock FIFO: write-pointer synchroniser, read pointer,
// prefetch control for the synchronous-read array and a two-entry FWFT output buffer.
module afifo_rd_port #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray_i,
  output logic [ADDR_WIDTH:0]   rptr_gray_o,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  level_err
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_reg;
  logic [PW-1:0]                  wg_s;
  logic [PW-1:0]                  wbin_s;
  logic [PW-1:0]                  rbin_reg;
  logic [PW-1:0]                  rbin_next;
  logic [PW-1:0]                  rptr_gray_reg;
  logic                           head_v_reg;
  logic                           skid_v_reg;
  logic                           inflight_reg;
  logic [DATA_WIDTH-1:0]          head_reg;
  logic [DATA_WIDTH-1:0]          skid_reg;
  logic                           level_err_reg;
  logic                           level_bad;
  logic                           pop;
  logic [1:0]                     slots_used;
  logic [1:0]                     slots_after_pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], wptr_gray_i};
    end
  end

  assign wg_s     = sync_reg[SYNC_STAGES-1];
  assign wbin_s   = gray2bin(wg_s);
  assign rd_level = wbin_s - rbin_reg;

  assign empty        = (rd_level == '0);
  assign almost_empty = (rd_level <= PW'(ALMOST_EMPTY_TH));

  // A level above DEPTH can only come from a corrupt pointer; stop reading at once.
  assign level_bad = level_err_reg || ({1'b0, rd_level} > (PW + 1)'(DEPTH));

  assign m_valid = head_v_reg;
  assign m_data  = head_reg;
  assign pop     = head_v_reg & m_ready;

  // The in-flight word already owns a buffer slot, so it counts toward the limit of two.
  assign slots_used      = 2'(head_v_reg) + 2'(skid_v_reg) + 2'(inflight_reg);
  assign slots_after_pop = slots_used - 2'(pop);

  assign mem_ren   = !empty && !level_bad && (slots_after_pop < 2'd2);
  assign mem_raddr = rbin_reg[ADDR_WIDTH-1:0];
  assign rbin_next = rbin_reg + PW'(mem_ren);

  assign rptr_gray_o = rptr_gray_reg;
  assign level_err   = level_err_reg;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_reg      <= '0;
      rptr_gray_reg <= '0;
      inflight_reg  <= 1'b0;
      level_err_reg <= 1'b0;
    end else begin
      rbin_reg      <= rbin_next;
      rptr_gray_reg <= rbin_next ^ (rbin_next >> 1);
      inflight_reg  <= mem_ren;
      if ({1'b0, rd_level} > (PW + 1)'(DEPTH)) begin
        level_err_reg <= 1'b1;
      end
    end
  end

  // Head/skid update: skid advances on pop, returned word fills the earliest free slot.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_v_reg <= 1'b0;
      skid_v_reg <= 1'b0;
      head_reg   <= '0;
      skid_reg   <= '0;
    end else if (pop) begin
      if (skid_v_reg) begin
        head_reg   <= skid_reg;
        head_v_reg <= 1'b1;
        if (inflight_reg) begin
          skid_reg   <= mem_rdata;
          skid_v_reg <= 1'b1;
        end else begin
          skid_v_reg <= 1'b0;
        end
      end else if (inflight_reg) begin
        head_reg   <= mem_rdata;
        head_v_reg <= 1'b1;
      end else begin
        head_v_reg <= 1'b0;
      end
    end else if (inflight_reg) begin
      if (!head_v_reg) begin
        head_reg   <= mem_rdata;
        head_v_reg <= 1'b1;
      end else begin
        skid_reg   <= mem_rdata;
        skid_v_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_port.sv
// Randomised bench for afifo_rd_port: a write-side model fills a behavioural array and a
// word queue; every stream transfer is checked against that queue.
module tb_afifo_rd_port;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          rclk;
  logic          rrst_n;
  logic [PW-1:0] wptr_gray_i;
  logic [PW-1:0] rptr_gray_o;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [PW-1:0] rd_level;
  logic          empty;
  logic          almost_empty;
  logic          level_err;

  afifo_rd_port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2), .ALMOST_EMPTY_TH(1)
  ) dut (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray_i(wptr_gray_i), .rptr_gray_o(rptr_gray_o),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .rd_level(rd_level),
    .empty(empty), .almost_empty(almost_empty), .level_err(level_err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Behavioural synchronous-read storage array.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge rclk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [PW-1:0] wcnt;
  logic [PW-1:0] popped_n;
  logic [PW-1:0] prev_rptr;
  logic [DW-1:0] prev_data;
  logic          prev_stall;
  logic          xfer_now;
  int            ren_cnt;
  int            wr_total;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] r;
    r = '0;
    for (int b = 0; b < (1 << PW); b++) if (b2g(PW'(b)) == g) r = PW'(b);
    return r;
  endfunction

  // One rclk: drive at the falling edge, sample 1 ns later, score against the model.
  task automatic cycle(input logic rdy, input logic wr);
    logic [PW-1:0] diff;
    logic [PW-1:0] fetched;
    logic [DW-1:0] w;
    logic [DW-1:0] exp_w;
    @(negedge rclk);
    m_ready  = rdy;
    diff     = wcnt - g2b(rptr_gray_o);
    xfer_now = 1'b0;
    if (wr && diff < PW'(DEPTH)) begin
      w = DW'($urandom);
      mem[wcnt[AW-1:0]] = w;
      exp_q.push_back(w);
      wcnt = wcnt + 1'b1;
      wptr_gray_i = b2g(wcnt);
      wr_total++;
    end
    #1;
    n_checks++;
    if ($countones(rptr_gray_o ^ prev_rptr) > 1) begin
      n_fail++;
      $display("FAIL rptr_gray_step: %b -> %b, required at most one bit change", prev_rptr, rptr_gray_o);
    end
    fetched = g2b(rptr_gray_o) - popped_n;
    n_checks++;
    if (fetched > 4'd2) begin
      n_fail++;
      $display("FAIL prefetch_bound: %0d words fetched but unconsumed, required <= 2", fetched);
    end
    if (prev_stall) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== prev_data) begin
        n_fail++;
        $display("FAIL stall_hold: m_valid=%b m_data=%h, required 1 / %h", m_valid, m_data, prev_data);
      end
    end
    if (m_valid === 1'b1 && m_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_word: got %h, required no word", m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin
          n_fail++;
          $display("FAIL stream_data: got %h, required %h", m_data, exp_w);
        end
      end
      popped_n = popped_n + 1'b1;
      xfer_now = 1'b1;
    end
    if (mem_ren === 1'b1) ren_cnt++;
    prev_stall = (m_valid === 1'b1) && !m_ready;
    prev_data  = m_data;
    prev_rptr  = rptr_gray_o;
  endtask

  task automatic clear_model();
    wptr_gray_i = '0;
    wcnt        = '0;
    popped_n    = '0;
    prev_rptr   = '0;
    prev_stall  = 1'b0;
    ren_cnt     = 0;
    wr_total    = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    clear_model();
    repeat (3) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge rclk);
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1 || almost_empty !== 1'b1 || rptr_gray_o !== 4'b0000 ||
        level_err !== 1'b0 || mem_ren !== 1'b0 || rd_level !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b e=%b ae=%b rptr=%b err=%b ren=%b lvl=%0d, required 0 1 1 0000 0 0 0",
               m_valid, empty, almost_empty, rptr_gray_o, level_err, mem_ren, rd_level);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_first_word();
    logic          seen;
    logic [DW-1:0] w0;
    do_reset();
    cycle(1'b0, 1'b1);
    w0 = exp_q[0];
    n_checks++;
    if (mem_ren !== 1'b0) begin n_fail++; $display("FAIL ren_edge0: mem_ren=%b, required 0", mem_ren); end
    cycle(1'b0, 1'b0);
    n_checks++;
    if (mem_ren !== 1'b0) begin n_fail++; $display("FAIL ren_edge1: mem_ren=%b, required 0", mem_ren); end
    cycle(1'b0, 1'b0);
    n_checks++;
    if (mem_ren !== 1'b1 || mem_raddr !== 3'd0) begin
      n_fail++;
      $display("FAIL ren_edge2: mem_ren=%b raddr=%0d, required 1 / 0", mem_ren, mem_raddr);
    end
    n_checks++;
    if (rd_level !== 4'd1 || empty !== 1'b0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL level_one: lvl=%0d empty=%b ae=%b, required 1 0 1", rd_level, empty, almost_empty);
    end
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      cycle(1'b0, 1'b0);
      if (m_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || m_data !== w0) begin
      n_fail++;
      $display("FAIL first_word: valid_seen=%b data=%h, required 1 / %h", seen, m_data, w0);
    end
    n_checks++;
    if (rptr_gray_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_rptr: rptr=%b, required 0001", rptr_gray_o);
    end
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    n_checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL first_drain: left=%0d valid=%b empty=%b, required 0 0 1", exp_q.size(), m_valid, empty);
    end
  endtask

  task automatic test_stream8();
    logic [PW-1:0] seq[$];
    int            nx;
    int            first_x;
    int            last_x;
    do_reset();
    seq.push_back(rptr_gray_o);
    nx = 0; first_x = -1; last_x = -1;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, i < 8);
      if (rptr_gray_o != seq[$]) seq.push_back(rptr_gray_o);
      if (xfer_now) begin
        nx++;
        if (first_x < 0) first_x = i;
        last_x = i;
      end
    end
    n_checks++;
    if (nx != 8 || last_x - first_x != 7) begin
      n_fail++;
      $display("FAIL stream8_rate: %0d transfers over %0d cycles, required 8 over 7", nx, last_x - first_x);
    end
    n_checks++;
    if (seq.size() != 9) begin
      n_fail++;
      $display("FAIL rptr_seq_len: %0d distinct values, required 9", seq.size());
    end
    for (int k = 0; k < seq.size() && k < 9; k++) begin
      n_checks++;
      if (seq[k] !== b2g(PW'(k))) begin
        n_fail++;
        $display("FAIL rptr_seq[%0d]: %h, required %h", k, seq[k], b2g(PW'(k)));
      end
    end
  endtask

  task automatic test_backpressure();
    int nx;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0);
    n_checks++;
    if (ren_cnt != 2) begin
      n_fail++;
      $display("FAIL bp_ren_count: %0d reads, required 2", ren_cnt);
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b data=%h, required 1 / %h", m_valid, m_data, exp_q[0]);
    end
    n_checks++;
    if (rd_level !== 4'd3 || empty !== 1'b0 || almost_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_level: lvl=%0d empty=%b ae=%b, required 3 0 0", rd_level, empty, almost_empty);
    end
    nx = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      if (xfer_now) nx++;
    end
    n_checks++;
    if (nx != 5) begin
      n_fail++;
      $display("FAIL bp_release: %0d transfers in 5 cycles, required 5", nx);
    end
    repeat (3) cycle(1'b1, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int cyc;
    wr_total = 0;
    cyc = 0;
    while (cyc < 600 && !(wr_total >= 20 && exp_q.size() == 0)) begin
      cycle($urandom_range(0, 2) != 0, (wr_total < 20) && ($urandom_range(0, 3) != 0));
      cyc++;
    end
    n_checks++;
    if (cyc >= 600) begin
      n_fail++;
      $display("FAIL wrap_timeout: written=%0d left=%0d after %0d cycles, required all delivered", wr_total, exp_q.size(), cyc);
    end
    repeat (4) cycle(1'b1, 1'b0);
    n_checks++;
    if (rd_level !== 4'd0 || empty !== 1'b1 || m_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_end: lvl=%0d empty=%b valid=%b left=%0d, required 0 1 0 0", rd_level, empty, m_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    n_checks++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: valid=%b, required 1", m_valid); end
    #2;
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || rptr_gray_o !== 4'b0000 || mem_ren !== 1'b0 || rd_level !== 4'd0 ||
        m_data !== 8'h00 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b rptr=%b ren=%b lvl=%0d data=%h empty=%b, required 0 0000 0 0 00 1",
               m_valid, rptr_gray_o, mem_ren, rd_level, m_data, empty);
    end
    clear_model();
    m_ready = 1'b0;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    repeat (8) cycle(1'b1, 1'b0);
    n_checks++;
    if (exp_q.size() != 0 || rd_level !== 4'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_resume: left=%0d lvl=%0d valid=%b, required 0 0 0", exp_q.size(), rd_level, m_valid);
    end
  endtask

  task automatic test_level_err();
    int ren_seen;
    do_reset();
    @(negedge rclk);
    wptr_gray_i = 4'b1101;
    ren_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0);
      if (mem_ren !== 1'b0) ren_seen++;
    end
    n_checks++;
    if (ren_seen != 0) begin
      n_fail++;
      $display("FAIL err_blocks_ren: mem_ren seen %0d times, required 0", ren_seen);
    end
    n_checks++;
    if (level_err !== 1'b1 || rd_level !== 4'd9) begin
      n_fail++;
      $display("FAIL err_set: err=%b lvl=%0d, required 1 / 9", level_err, rd_level);
    end
    @(negedge rclk);
    wptr_gray_i = 4'b0000;
    repeat (4) cycle(1'b1, 1'b0);
    n_checks++;
    if (level_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b, required 1", level_err);
    end
    do_reset();
    cycle(1'b0, 1'b0);
    n_checks++;
    if (level_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b, required 0", level_err);
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_stream8();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
    test_level_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
